threefish_key_schedule: RTL and testbench

- Key-schedule generator that feeds the per-word subkey registers of the Threefish-1024 datapath in the Skein hash engine.
- Holds the 16 key words, the parity word and the 3 tweak words.
- On request, it computes subkey s (0..20) and streams its 16 words, one per cycle, with a write strobe and a word select.
- The word select is decoded downstream into the write enables of the 16 subkey registers.

---
 rtl/threefish_key_schedule.sv | 244 ++++++++++++++++++++++++
 tb/tb_threefish_key_schedule.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/threefish_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : threefish_key_schedule
// Purpose  : Threefish-1024 key-schedule generator. Holds k0..k15, the parity
//            word k16 and the tweak words t0..t2. On request it streams the 16
//            words of subkey s, one per cycle, with a write strobe and a word
//            select for the downstream subkey registers.
// Ports    : clk_i, rst_n_i         clock / async active-low reset
//            load_i, key_valid_i,   key/tweak load (k0..k15, t0, t1)
//            key_word_i
//            key_ready_o            key material complete
//            req_i, subkey_idx_i    subkey emission request
//            write_o, word_sel_o,   registered word stream
//            word_o
//            busy_o, done_o         status / end-of-subkey pulse
//            err_o                  out-of-range request (optional)
// Options  : KEYSCHED_RANGE_CHECK_EN adds err_o and rejects out-of-range
//            subkey indices; otherwise they are emitted with s as given.
// Revision : 1.0 - initial release
// ============================================================================
module threefish_key_schedule #(
    parameter int unsigned NUM_SUBKEYS = 21,
    parameter logic [63:0] KS_PARITY   = 64'h1BD11BDAA9FC1A22
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        load_i,
    input  logic        key_valid_i,
    input  logic [63:0] key_word_i,
    output logic        key_ready_o,
    input  logic        req_i,
    input  logic [4:0]  subkey_idx_i,
    output logic        write_o,
    output logic [3:0]  word_sel_o,
    output logic [63:0] word_o,
    output logic        busy_o,
`ifdef KEYSCHED_RANGE_CHECK_EN
    output logic        err_o,
`endif
    output logic        done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    // The subkey index port is 5 bits wide, so larger subkey counts are unusable.
    if (NUM_SUBKEYS > 32) begin : g_num_subkeys_check
        $error("NUM_SUBKEYS exceeds the range of subkey_idx_i");
    end

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;          // load slot counter, 0..17
    logic [63:0] k_q [0:16];
    logic [63:0] k_d [0:16];
    logic [63:0] t_q [0:2];
    logic [63:0] t_d [0:2];
    logic [4:0]  s_q, s_d;              // latched subkey index
    logic [1:0]  m_q, m_d;              // s mod 3
    logic [4:0]  i_q, i_d;              // next word index to emit, 16 = finished
    logic [4:0]  j_q, j_d;              // (s + i) mod 17 for the next word
    logic        write_q, write_d;
    logic [3:0]  word_sel_q, word_sel_d;
    logic [63:0] word_q, word_d;
    logic        done_q, done_d;
`ifdef KEYSCHED_RANGE_CHECK_EN
    logic        err_q, err_d;
`endif

    // Word generator operands: taken straight from the request port while
    // accepting (so word 0 is registered on the accept edge), from the
    // latched state while emitting.
    logic [4:0]  gen_s, gen_j, gen_j_inc;
    logic [3:0]  gen_i;
    logic [1:0]  gen_m, gen_m1;
    logic [63:0] gen_base, gen_word;

    // s mod 3 by repeated compare-subtract; s is at most 31.
    function automatic logic [1:0] mod3(input logic [4:0] v);
        logic [4:0] r;
        r = v;
        for (int n = 0; n < 10; n++) begin
            if (r >= 5'd3) r = r - 5'd3;
        end
        return r[1:0];
    endfunction

    always_comb begin
        if (state_q == ST_READY) begin
            gen_s = subkey_idx_i;
            gen_j = (subkey_idx_i >= 5'd17) ? subkey_idx_i - 5'd17 : subkey_idx_i;
            gen_i = 4'd0;
            gen_m = mod3(subkey_idx_i);
        end else begin
            gen_s = s_q;
            gen_j = j_q;
            gen_i = i_q[3:0];
            gen_m = m_q;
        end
        gen_j_inc = (gen_j == 5'd16) ? 5'd0 : gen_j + 5'd1;
        gen_m1    = (gen_m == 2'd2) ? 2'd0 : gen_m + 2'd1;
        gen_base  = k_q[gen_j];
        unique case (gen_i)
            4'd13:   gen_word = gen_base + t_q[gen_m];
            4'd14:   gen_word = gen_base + t_q[gen_m1];
            4'd15:   gen_word = gen_base + {59'd0, gen_s};
            default: gen_word = gen_base;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        t_d        = t_q;
        s_d        = s_q;
        m_d        = m_q;
        i_d        = i_q;
        j_d        = j_q;
        write_d    = 1'b0;
        word_sel_d = 4'd0;
        word_d     = 64'd0;
        done_d     = 1'b0;
`ifdef KEYSCHED_RANGE_CHECK_EN
        err_d      = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    state_d = ST_LOAD;
                    cnt_d   = 5'd0;
                    k_d[16] = KS_PARITY;
                end
            end
            ST_LOAD: begin
                if (load_i) begin
                    cnt_d   = 5'd0;
                    k_d[16] = KS_PARITY;
                end else if (key_valid_i) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q < 5'd16) begin
                        // k16 doubles as the parity accumulator, so it already
                        // holds the final parity when t1 arrives.
                        k_d[cnt_q] = key_word_i;
                        k_d[16]    = k_q[16] ^ key_word_i;
                    end else if (cnt_q == 5'd16) begin
                        t_d[0] = key_word_i;
                    end else begin
                        t_d[1]  = key_word_i;
                        t_d[2]  = t_q[0] ^ key_word_i;
                        state_d = ST_READY;
                    end
                end
            end
            ST_READY: begin
                if (load_i) begin
                    state_d = ST_LOAD;
                    cnt_d   = 5'd0;
                    k_d[16] = KS_PARITY;
                end else if (req_i) begin
`ifdef KEYSCHED_RANGE_CHECK_EN
                    if ({27'd0, subkey_idx_i} >= NUM_SUBKEYS) begin
                        err_d = 1'b1;
                    end else
`endif
                    begin
                        state_d    = ST_EMIT;
                        s_d        = gen_s;
                        m_d        = gen_m;
                        write_d    = 1'b1;
                        word_sel_d = 4'd0;
                        word_d     = gen_word;
                        i_d        = 5'd1;
                        j_d        = gen_j_inc;
                    end
                end
            end
            ST_EMIT: begin
                if (i_q == 5'd16) begin
                    done_d  = 1'b1;
                    state_d = ST_READY;
                end else begin
                    write_d    = 1'b1;
                    word_sel_d = i_q[3:0];
                    word_d     = gen_word;
                    i_d        = i_q + 5'd1;
                    j_d        = gen_j_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            for (int n = 0; n < 17; n++) k_q[n] <= 64'd0;
            for (int n = 0; n < 3; n++)  t_q[n] <= 64'd0;
            s_q        <= 5'd0;
            m_q        <= 2'd0;
            i_q        <= 5'd0;
            j_q        <= 5'd0;
            write_q    <= 1'b0;
            word_sel_q <= 4'd0;
            word_q     <= 64'd0;
            done_q     <= 1'b0;
`ifdef KEYSCHED_RANGE_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            t_q        <= t_d;
            s_q        <= s_d;
            m_q        <= m_d;
            i_q        <= i_d;
            j_q        <= j_d;
            write_q    <= write_d;
            word_sel_q <= word_sel_d;
            word_q     <= word_d;
            done_q     <= done_d;
`ifdef KEYSCHED_RANGE_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign key_ready_o = (state_q == ST_READY);
    assign busy_o      = (state_q == ST_LOAD) || (state_q == ST_EMIT);
    assign write_o     = write_q;
    assign word_sel_o  = word_sel_q;
    assign word_o      = word_q;
    assign done_o      = done_q;
`ifdef KEYSCHED_RANGE_CHECK_EN
    assign err_o       = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_threefish_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_threefish_key_schedule
// Purpose  : Self-checking bench for threefish_key_schedule. A reference model
//            of the key schedule pushes expected {word_sel, word} pairs into a
//            scoreboard queue on each request; they are popped as the DUT
//            raises write_o.
// Revision : 1.0 - initial release
// ============================================================================
module tb_threefish_key_schedule;

    localparam logic [63:0] C_PARITY = 64'h1BD11BDAA9FC1A22;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        load_i;
    logic        key_valid_i;
    logic [63:0] key_word_i;
    logic        key_ready_o;
    logic        req_i;
    logic [4:0]  subkey_idx_i;
    logic        write_o;
    logic [3:0]  word_sel_o;
    logic [63:0] word_o;
    logic        busy_o;
    logic        done_o;
`ifdef KEYSCHED_RANGE_CHECK_EN
    logic        err_o;
`endif

    threefish_key_schedule dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .load_i       (load_i),
        .key_valid_i  (key_valid_i),
        .key_word_i   (key_word_i),
        .key_ready_o  (key_ready_o),
        .req_i        (req_i),
        .subkey_idx_i (subkey_idx_i),
        .write_o      (write_o),
        .word_sel_o   (word_sel_o),
        .word_o       (word_o),
        .busy_o       (busy_o),
`ifdef KEYSCHED_RANGE_CHECK_EN
        .err_o        (err_o),
`endif
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] mk [0:16];
    logic [63:0] mt [0:2];
    logic [67:0] sb [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_word(input int s, input int i);
        logic [63:0] b;
        b = mk[(s + i) % 17];
        if (i == 13)      b = b + mt[s % 3];
        else if (i == 14) b = b + mt[(s + 1) % 3];
        else if (i == 15) b = b + 64'(s);
        return b;
    endfunction

    // Sends k0..k15, t0, t1 with one gap cycle; completes the model's k16/t2.
    task automatic do_load();
        mk[16] = C_PARITY;
        for (int n = 0; n < 16; n++) mk[16] = mk[16] ^ mk[n];
        mt[2] = mt[0] ^ mt[1];
        @(negedge clk_i);
        load_i = 1'b1;
        @(negedge clk_i);
        load_i = 1'b0;
        for (int n = 0; n < 18; n++) begin
            if (n == 5) begin
                key_valid_i = 1'b0;
                @(negedge clk_i);
            end
            if (n == 10) begin
                chk("load_busy", {63'd0, busy_o}, 64'd1);
                chk("load_not_ready", {63'd0, key_ready_o}, 64'd0);
            end
            key_valid_i = 1'b1;
            key_word_i  = (n < 16) ? mk[n] : mt[n - 16];
            @(negedge clk_i);
        end
        key_valid_i = 1'b0;
        chk("ready_after_load", {63'd0, key_ready_o}, 64'd1);
    endtask

    task automatic do_req(input int s, input bit inject);
        int writes;
        int first_c;
        bit seen_done;
        logic [67:0] e;
        for (int i = 0; i < 16; i++) sb.push_back({4'(i), model_word(s, i)});
        req_i        = 1'b1;
        subkey_idx_i = 5'(s);
        @(negedge clk_i);
        req_i     = 1'b0;
        writes    = 0;
        first_c   = -1;
        seen_done = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            if (inject && c == 3) begin
                load_i = 1'b1; req_i = 1'b1; subkey_idx_i = 5'd7;
            end else begin
                load_i = 1'b0; req_i = 1'b0;
            end
            if (write_o) begin
                if (first_c < 0) begin
                    first_c = c;
                    chk("emit_busy", {63'd0, busy_o}, 64'd1);
                    chk("emit_not_ready", {63'd0, key_ready_o}, 64'd0);
                end
                chk($sformatf("s%0d_sb_has_entry", s), {63'd0, sb.size() > 0}, 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk($sformatf("s%0d_sel%0d", s, writes), {60'd0, word_sel_o}, {60'd0, e[67:64]});
                    chk($sformatf("s%0d_word%0d", s, writes), word_o, e[63:0]);
                end
                writes++;
            end
            if (done_o) begin
                seen_done = 1'b1;
                chk($sformatf("s%0d_done_cycle", s), 64'(c), 64'd16);
                chk($sformatf("s%0d_done_ready", s), {63'd0, key_ready_o}, 64'd1);
            end else begin
                @(negedge clk_i);
            end
        end
        load_i = 1'b0;
        req_i  = 1'b0;
        chk($sformatf("s%0d_first_write", s), 64'(first_c), 64'd0);
        chk($sformatf("s%0d_write_count", s), 64'(writes), 64'd16);
        chk($sformatf("s%0d_done_seen", s), {63'd0, seen_done}, 64'd1);
        sb.delete();
    endtask

    initial begin
        int nw;
        bit hit;
        rst_n_i      = 1'b0;
        load_i       = 1'b0;
        key_valid_i  = 1'b0;
        key_word_i   = 64'd0;
        req_i        = 1'b0;
        subkey_idx_i = 5'd0;
        repeat (3) @(negedge clk_i);
        chk("rst_write", {63'd0, write_o}, 64'd0);
        chk("rst_sel", {60'd0, word_sel_o}, 64'd0);
        chk("rst_word", word_o, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_ready", {63'd0, key_ready_o}, 64'd0);
        chk("rst_done", {63'd0, done_o}, 64'd0);
        rst_n_i = 1'b1;

        // Test 1: all-zero key material, subkey 1
        for (int n = 0; n < 17; n++) mk[n] = 64'd0;
        for (int n = 0; n < 3; n++) mt[n] = 64'd0;
        do_load();
        do_req(1, 1'b0);

        // Tests 2..4: k_j = j, t0 = 0x100, t1 = 0x200
        for (int n = 0; n < 16; n++) mk[n] = 64'(n);
        mt[0] = 64'h100;
        mt[1] = 64'h200;
        do_load();
        do_req(0, 1'b0);
        do_req(2, 1'b0);
        do_req(20, 1'b0);

        // Test 5: interference during EMIT, then load+req together in READY
        do_req(5, 1'b1);
        @(negedge clk_i);
        load_i = 1'b1; req_i = 1'b1; subkey_idx_i = 5'd0;
        @(negedge clk_i);
        load_i = 1'b0; req_i = 1'b0;
        chk("loadreq_busy", {63'd0, busy_o}, 64'd1);
        chk("loadreq_not_ready", {63'd0, key_ready_o}, 64'd0);
        chk("loadreq_no_write", {63'd0, write_o}, 64'd0);
        @(negedge clk_i);
        chk("loadreq_no_write2", {63'd0, write_o}, 64'd0);
        do_load();

`ifdef KEYSCHED_RANGE_CHECK_EN
        req_i = 1'b1; subkey_idx_i = 5'd21;
        @(negedge clk_i);
        req_i = 1'b0;
        chk("range_err", {63'd0, err_o}, 64'd1);
        chk("range_no_write", {63'd0, write_o}, 64'd0);
        chk("range_ready", {63'd0, key_ready_o}, 64'd1);
        @(negedge clk_i);
        chk("range_err_pulse", {63'd0, err_o}, 64'd0);
        chk("range_no_write2", {63'd0, write_o}, 64'd0);
`endif

        // Test 6: reset at EMIT word 7
        req_i = 1'b1; subkey_idx_i = 5'd0;
        @(negedge clk_i);
        req_i = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            if (write_o && word_sel_o == 4'd7) hit = 1'b1;
            else @(negedge clk_i);
        end
        chk("reached_word7", {63'd0, hit}, 64'd1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst_write", {63'd0, write_o}, 64'd0);
        chk("arst_busy", {63'd0, busy_o}, 64'd0);
        chk("arst_ready", {63'd0, key_ready_o}, 64'd0);
        chk("arst_word", word_o, 64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        req_i = 1'b1; subkey_idx_i = 5'd0;
        @(negedge clk_i);
        req_i = 1'b0;
        nw = 0;
        for (int c = 0; c < 20; c++) begin
            if (write_o) nw++;
            @(negedge clk_i);
        end
        chk("idle_req_ignored", 64'(nw), 64'd0);
        chk("idle_busy", {63'd0, busy_o}, 64'd0);
        chk("idle_ready", {63'd0, key_ready_o}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
